// File: rtl/clk_div_pkg.sv
// Shared types and constants for the multi-channel clock/pattern divider.
// Holds the per-channel FSM state type, the config record and default sizes.
// Config record fields are stored at fixed maximum widths (CFG_CNT_MAX and CFG_PUL_MAX) and zero-extended from the port widths.
package clk_div_pkg;

  localparam int DEF_NUM_CH  = 4;
  localparam int DEF_CNT_W   = 28;
  localparam int DEF_PUL_W   = 4;

  // Storage width of the config record; CNT_W / PUL_W must not exceed these.
  localparam int CFG_CNT_MAX = 32;
  localparam int CFG_PUL_MAX = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_GAP  = 2'd3
  } ch_state_e;

  typedef struct packed {
    logic [CFG_CNT_MAX-1:0] half;
    logic [CFG_PUL_MAX-1:0] pulses;
    logic [CFG_CNT_MAX-1:0] gap;
    logic                   pol;
  } cfg_t;

  localparam cfg_t CFG_DEFAULT = '{
    half:   CFG_CNT_MAX'(1),
    pulses: CFG_PUL_MAX'(1),
    gap:    '0,
    pol:    1'b0
  };

endpackage

// File: rtl/multi_clk_div_if.sv
// Config write bus of multi_clk_div (valid/ready handshake plus payload).
// master: drives cfg_valid/cfg_ch/cfg_half/cfg_pulses/cfg_gap[/cfg_pol]; slave: drives cfg_ready.
// Macro CLK_DIV_POLARITY_EN adds the cfg_pol payload bit.
interface multi_clk_div_if
  import clk_div_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int PUL_W  = DEF_PUL_W
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_half;
  logic [PUL_W-1:0] cfg_pulses;
  logic [CNT_W-1:0] cfg_gap;
`ifdef CLK_DIV_POLARITY_EN
  logic             cfg_pol;
`endif

  modport master (
    output cfg_valid, cfg_ch, cfg_half, cfg_pulses, cfg_gap,
`ifdef CLK_DIV_POLARITY_EN
    output cfg_pol,
`endif
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_half, cfg_pulses, cfg_gap,
`ifdef CLK_DIV_POLARITY_EN
    input  cfg_pol,
`endif
    output cfg_ready
  );

endinterface

// File: rtl/multi_clk_div_ch.sv
// One divider channel: IDLE/HIGH/LOW/GAP pattern generator with active + shadow config.
// Ports: clk, reset, en, wr/wr_cfg (shadow load), out_clk (registered), frame_done, pending.
// Shadow is applied while IDLE or on the frame boundary cycle; half=0 keeps the channel IDLE.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int PUL_W = DEF_PUL_W
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic wr,
  input  cfg_t wr_cfg,
  output logic out_clk,
  output logic frame_done,
  output logic pending
);

  ch_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [PUL_W-1:0] pcnt, pcnt_nxt;
  cfg_t             act, shd, eff;
  logic             pend;
  logic             phase_end, last_pulse, boundary, apply;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      pcnt    <= '0;
      act     <= CFG_DEFAULT;
      shd     <= CFG_DEFAULT;
      pend    <= 1'b0;
      out_clk <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pcnt    <= pcnt_nxt;
      out_clk <= (state_nxt == ST_HIGH) ^ eff.pol;
      if (apply) begin
        act  <= shd;
        pend <= 1'b0;
      end
      // A write is only accepted while nothing is pending, so it never races apply.
      if (wr) begin
        shd  <= wr_cfg;
        pend <= 1'b1;
      end
    end
  end

  always_comb begin
    phase_end  = 1'b0;
    last_pulse = 1'b0;
    boundary   = 1'b0;
    apply      = 1'b0;
    eff        = act;
    state_nxt  = state;
    cnt_nxt    = cnt;
    pcnt_nxt   = pcnt;

    // Counters run 0..N-1; compare at storage width so half = 2^CNT_W-1 never wraps.
    case (state)
      ST_HIGH, ST_LOW: phase_end = (CFG_CNT_MAX'(cnt) == act.half - CFG_CNT_MAX'(1));
      ST_GAP:          phase_end = (CFG_CNT_MAX'(cnt) == act.gap - CFG_CNT_MAX'(1));
      default:         phase_end = 1'b0;
    endcase

    // pulses = 0 behaves as a single pulse per frame.
    last_pulse = (act.pulses == '0) ||
                 (CFG_PUL_MAX'(pcnt) == act.pulses - CFG_PUL_MAX'(1));

    boundary = phase_end &&
               ((state == ST_GAP) ||
                (state == ST_LOW && last_pulse && act.gap == '0));

    apply = pend && ((state == ST_IDLE) || boundary);
    if (apply) eff = shd;

    if (!en) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
      pcnt_nxt  = '0;
    end else if (state == ST_IDLE || boundary) begin
      // Start (or restart) a frame with whatever config is active after this edge.
      cnt_nxt   = '0;
      pcnt_nxt  = '0;
      state_nxt = (eff.half != '0) ? ST_HIGH : ST_IDLE;
    end else if (phase_end) begin
      cnt_nxt = '0;
      case (state)
        ST_HIGH: state_nxt = ST_LOW;
        ST_LOW: begin
          if (last_pulse) begin
            state_nxt = ST_GAP;
            pcnt_nxt  = '0;
          end else begin
            state_nxt = ST_HIGH;
            pcnt_nxt  = pcnt + PUL_W'(1);
          end
        end
        default: state_nxt = state;  // end of GAP is always a boundary
      endcase
    end else begin
      cnt_nxt = cnt + CNT_W'(1);
    end
  end

  assign frame_done = boundary;
  assign pending    = pend;

endmodule

// File: rtl/multi_clk_div.sv
// NUM_CH independent clock/pattern dividers sharing one config write port.
// Ports: clk, reset, en[NUM_CH], cfg (multi_clk_div_if.slave), out_clk[NUM_CH], frame_done[NUM_CH].
// cfg_ready drops only while the addressed channel holds an unapplied shadow; out-of-range writes are accepted and dropped. Macro CLK_DIV_POLARITY_EN adds cfg_pol.
module multi_clk_div
  import clk_div_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int PUL_W  = DEF_PUL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] en,
  multi_clk_div_if.slave    cfg,
  output logic [NUM_CH-1:0] out_clk,
  output logic [NUM_CH-1:0] frame_done
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] wr;
  logic              busy;
  cfg_t              wr_cfg;

  // Channel decode: an index matching no channel leaves busy=0 and wr=0,
  // so such writes complete immediately and are discarded.
  always_comb begin
    busy = 1'b0;
    wr   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg.cfg_ch == CH_W'(i)) busy = pending[i];
    end
    cfg.cfg_ready = !busy;
    for (int i = 0; i < NUM_CH; i++) begin
      wr[i] = cfg.cfg_valid && !busy && (cfg.cfg_ch == CH_W'(i));
    end
  end

  always_comb begin
    wr_cfg        = CFG_DEFAULT;
    wr_cfg.half   = CFG_CNT_MAX'(cfg.cfg_half);
    wr_cfg.pulses = CFG_PUL_MAX'(cfg.cfg_pulses);
    wr_cfg.gap    = CFG_CNT_MAX'(cfg.cfg_gap);
`ifdef CLK_DIV_POLARITY_EN
    wr_cfg.pol    = cfg.cfg_pol;
`else
    wr_cfg.pol    = 1'b0;
`endif
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_ch #(
      .CNT_W (CNT_W),
      .PUL_W (PUL_W)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .en         (en[g]),
      .wr         (wr[g]),
      .wr_cfg     (wr_cfg),
      .out_clk    (out_clk[g]),
      .frame_done (frame_done[g]),
      .pending    (pending[g])
    );
  end

endmodule
